field_arbiter: RTL and testbench
================================

// Module: field_arbiter
// PURPOSE
// Owns the 10x15 playfield map (150 cells x 2 bits) and shares it between game logic (read/write) and video renderer (read-only).
// Sequences food_generator: resets it, waits for busy low, snapshots its food map, then counts food cells.
// Signals level completion when the last food cell is eaten and regenerates the field on request.
// PARAMETERS
// W          10   field width in cells
// H          15   field height in cells
// MAX_WAIT   4    cycles a pending video request may lose arbitration before it is forced through
// GEN_RST_CY 2    cycles gen_rst is held high per regeneration
// PORTS
// clk         in   1    system clock
// rst         in   1    synchronous active-high reset
// gen_rst     out  1    reset pulse to food_generator
// gen_busy    in   1    food_generator busy
// gen_food    in   300  food_generator map, cell k at bits [2k+1:2k]
// new_level   in   1    pulse: regenerate field (honoured only in S_DONE)
// game_req    in   1    game access request, held until game_ack
// game_we     in   1    1 = write game_wdata, 0 = read
// game_idx    in   8    cell index 10*row+col
// game_wdata  in   2    write data
// game_ack    out  1    one-cycle access completion
// game_rdata  out  2    cell value before any write, valid with game_ack
// vid_req     in   1    video read request, held until vid_ack
// vid_idx     in   8    cell index
// vid_ack     out  1    one-cycle completion
// vid_rdata   out  2    cell value, valid with vid_ack
// food_left   out  8    food cells remaining
// ready       out  1    1 in S_RUN only
// level_done  out  1    one-cycle pulse on entering S_DONE
// BEHAVIOUR
// Cell codes: 2'b01 empty, 2'b10 food, 2'b11 and 2'b00 wall.
// Reset: state S_GEN, gen_rst=1, acks/level_done/ready=0, food_left=0, map all 2'b11.
// FSM:
//  S_GEN: gen_rst=1 for GEN_RST_CY cycles -> S_WAIT.
//  S_WAIT: ignore gen_busy on the first cycle; then on gen_busy==0 latch gen_food into map -> S_COUNT.
//  S_COUNT: scan one cell per cycle, idx 0..149, food_left += (cell==2'b10); after idx 149 -> S_RUN (150 cycles).
//  S_RUN: serve requests; food_left==0 after a write (or on entry) -> S_DONE.
//  S_DONE: level_done pulses on entry; reads still served, writes acked but ignored; new_level -> S_GEN.
// Requests outside S_RUN/S_DONE are held (no ack) until S_RUN.
// Arbitration: at most one access granted per cycle; ack and rdata registered, one cycle after grant.
//  Game has priority; vid_wait counts cycles vid_req is pending and not granted; vid_wait==MAX_WAIT forces a video grant.
//  vid_wait clears on video grant. No requester is granted again while its ack is pending: min 2 cycles per access per port.
// Write: map[idx] <= wdata. If old==food and new!=food, food_left-1; if old!=food and new==food, food_left+1.
// idx>=150: ack normally, rdata=2'b11, write discarded, food_left unchanged.
// rst mid-operation: return to reset state immediately; pending acks are dropped and requesters must re-request.
// new_level outside S_DONE: ignored.
// STRUCTURE
// Package field_pkg: W, H, CELLS=W*H, CELL_EMPTY/CELL_FOOD/CELL_WALL, state encoding.
// Sub-module field_grant: fixed priority plus vid_wait aging counter; outputs grant_game, grant_vid.
// Map storage, FSM, counting and food_left live in field_arbiter.
// TESTING
// Reset, generator busy for 20 cycles -> gen_rst high 2 cycles, snapshot when busy falls, ready 150 cycles later, food_left equals a reference count.
// Game write 2'b01 to a food cell idx 12 -> ack next cycle, rdata 2'b10, food_left decrements by 1.
// game_req and vid_req held continuously -> video acked at least once every MAX_WAIT+2 cycles, game never starved.
// Read and write with idx 200 -> ack, rdata 2'b11, map and food_left unchanged.
// Eat every food cell -> level_done pulses once, ready=0; new_level -> gen_rst again, new map loaded.
// rst asserted during S_COUNT -> food_left=0, no ack, and the sequence restarts cleanly from S_GEN.

Source files
------------

// File: rtl/field_pkg.sv
// Shared constants and state encoding for the playfield arbiter and its grant logic.
package field_pkg;
    localparam int W     = 10;
    localparam int H     = 15;
    localparam int CELLS = W * H;
    localparam int IDX_W = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b01;
    localparam logic [1:0] CELL_FOOD  = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    typedef enum logic [2:0] {
        S_GEN,
        S_WAIT,
        S_COUNT,
        S_RUN,
        S_DONE
    } state_t;
endpackage

// File: rtl/field_grant.sv
// Single-grant-per-cycle arbiter: game wins by default, video is forced through
// once it has been passed over MAX_WAIT times in a row.
module field_grant
    import field_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic game_req,
    input  logic game_busy,
    input  logic vid_req,
    input  logic vid_busy,
    output logic grant_game,
    output logic grant_vid
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] vid_wait_reg;
    logic          game_ok;
    logic          vid_ok;
    logic          vid_force;

    // A port whose ack is still on the wire is not eligible, so each port
    // sees at most one access every two cycles.
    always_comb begin
        game_ok    = en && game_req && !game_busy;
        vid_ok     = en && vid_req && !vid_busy;
        vid_force  = (vid_wait_reg == CW'(MAX_WAIT));
        grant_vid  = vid_ok && (!game_ok || vid_force);
        grant_game = game_ok && !grant_vid;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            vid_wait_reg <= '0;
        end else if (grant_vid || !vid_req) begin
            vid_wait_reg <= '0;
        end else if (vid_ok && !vid_force) begin
            vid_wait_reg <= vid_wait_reg + 1'b1;
        end
    end
endmodule

// File: rtl/field_arbiter.sv
// Playfield map owner: sequences the food generator, counts food, and serves
// game (read/write) and video (read-only) accesses with registered acks.
module field_arbiter
    import field_pkg::*;
#(
    parameter int MAX_WAIT   = 4,
    parameter int GEN_RST_CY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 gen_rst,
    input  logic                 gen_busy,
    input  logic [2*CELLS-1:0]   gen_food,
    input  logic                 new_level,
    input  logic                 game_req,
    input  logic                 game_we,
    input  logic [IDX_W-1:0]     game_idx,
    input  logic [1:0]           game_wdata,
    output logic                 game_ack,
    output logic [1:0]           game_rdata,
    input  logic                 vid_req,
    input  logic [IDX_W-1:0]     vid_idx,
    output logic                 vid_ack,
    output logic [1:0]           vid_rdata,
    output logic [IDX_W-1:0]     food_left,
    output logic                 ready,
    output logic                 level_done
);
    localparam int POS_W = $clog2(2 * CELLS);
    localparam int GC_W  = $clog2(GEN_RST_CY + 1);

    state_t              state_reg;
    logic [2*CELLS-1:0]  map_reg;
    logic [IDX_W-1:0]    scan_idx_reg;
    logic [IDX_W-1:0]    food_left_reg;
    logic [GC_W-1:0]     gen_cnt_reg;
    logic                wait_first_reg;
    logic                gen_rst_reg;
    logic                ready_reg;
    logic                level_done_reg;
    logic                game_ack_reg;
    logic                vid_ack_reg;
    logic [1:0]          game_rdata_reg;
    logic [1:0]          vid_rdata_reg;

    logic                serving;
    logic                grant_game;
    logic                grant_vid;
    logic [IDX_W-1:0]    acc_idx;
    logic [POS_W-1:0]    acc_pos;
    logic                acc_valid;
    logic [1:0]          acc_old;
    logic                wr_en;
    logic [IDX_W-1:0]    food_after_wr;
    logic [POS_W-1:0]    scan_pos;
    logic [1:0]          scan_cell;
    logic [IDX_W-1:0]    food_scan_next;

    assign serving = (state_reg == S_RUN) || (state_reg == S_DONE);

    field_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk        (clk),
        .srst       (rst),
        .en         (serving),
        .game_req   (game_req),
        .game_busy  (game_ack_reg),
        .vid_req    (vid_req),
        .vid_busy   (vid_ack_reg),
        .grant_game (grant_game),
        .grant_vid  (grant_vid)
    );

    always_comb begin
        acc_idx   = grant_game ? game_idx : vid_idx;
        acc_pos   = POS_W'({acc_idx, 1'b0});
        acc_valid = (acc_idx < IDX_W'(CELLS));
        acc_old   = CELL_WALL;
        if (acc_valid) begin
            acc_old = map_reg[acc_pos +: 2];
        end
        // Writes only land while the level is live; in S_DONE they are acked and dropped.
        wr_en         = grant_game && game_we && acc_valid && (state_reg == S_RUN);
        food_after_wr = food_left_reg;
        if (wr_en) begin
            if (acc_old == CELL_FOOD && game_wdata != CELL_FOOD) begin
                food_after_wr = food_left_reg - 1'b1;
            end else if (acc_old != CELL_FOOD && game_wdata == CELL_FOOD) begin
                food_after_wr = food_left_reg + 1'b1;
            end
        end
        scan_pos       = POS_W'({scan_idx_reg, 1'b0});
        scan_cell      = map_reg[scan_pos +: 2];
        food_scan_next = food_left_reg + IDX_W'(scan_cell == CELL_FOOD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_GEN;
            map_reg        <= '1;
            scan_idx_reg   <= '0;
            food_left_reg  <= '0;
            gen_cnt_reg    <= '0;
            wait_first_reg <= 1'b0;
            gen_rst_reg    <= 1'b1;
            ready_reg      <= 1'b0;
            level_done_reg <= 1'b0;
            game_ack_reg   <= 1'b0;
            vid_ack_reg    <= 1'b0;
            game_rdata_reg <= '0;
            vid_rdata_reg  <= '0;
        end else begin
            game_ack_reg   <= grant_game;
            vid_ack_reg    <= grant_vid;
            level_done_reg <= 1'b0;
            if (grant_game) game_rdata_reg <= acc_old;
            if (grant_vid)  vid_rdata_reg  <= acc_old;
            if (wr_en)      map_reg[acc_pos +: 2] <= game_wdata;

            case (state_reg)
                S_GEN: begin
                    if (gen_cnt_reg == GC_W'(GEN_RST_CY - 1)) begin
                        state_reg      <= S_WAIT;
                        gen_rst_reg    <= 1'b0;
                        wait_first_reg <= 1'b1;
                    end else begin
                        gen_cnt_reg <= gen_cnt_reg + 1'b1;
                    end
                end
                S_WAIT: begin
                    // gen_busy may still be stale right after gen_rst drops.
                    if (wait_first_reg) begin
                        wait_first_reg <= 1'b0;
                    end else if (!gen_busy) begin
                        map_reg       <= gen_food;
                        scan_idx_reg  <= '0;
                        food_left_reg <= '0;
                        state_reg     <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    food_left_reg <= food_scan_next;
                    scan_idx_reg  <= scan_idx_reg + 1'b1;
                    if (scan_idx_reg == IDX_W'(CELLS - 1)) begin
                        if (food_scan_next == '0) begin
                            state_reg      <= S_DONE;
                            level_done_reg <= 1'b1;
                        end else begin
                            state_reg <= S_RUN;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    food_left_reg <= food_after_wr;
                    if (food_after_wr == '0) begin
                        state_reg      <= S_DONE;
                        ready_reg      <= 1'b0;
                        level_done_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (new_level) begin
                        state_reg   <= S_GEN;
                        gen_rst_reg <= 1'b1;
                        gen_cnt_reg <= '0;
                    end
                end
                default: state_reg <= S_GEN;
            endcase
        end
    end

    assign gen_rst    = gen_rst_reg;
    assign game_ack   = game_ack_reg;
    assign game_rdata = game_rdata_reg;
    assign vid_ack    = vid_ack_reg;
    assign vid_rdata  = vid_rdata_reg;
    assign food_left  = food_left_reg;
    assign ready      = ready_reg;
    assign level_done = level_done_reg;
endmodule

// File: tb/tb_field_arbiter.sv
// Directed sequence with randomized maps and accesses, checked against a
// cell-array model of the playfield whose food count is recomputed from scratch.
module tb_field_arbiter;
    import field_pkg::*;

    localparam int NC      = CELLS;
    localparam int TB_WAIT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                gen_rst;
    logic                gen_busy;
    logic [2*NC-1:0]     gen_food;
    logic                new_level;
    logic                game_req;
    logic                game_we;
    logic [7:0]          game_idx;
    logic [1:0]          game_wdata;
    logic                game_ack;
    logic [1:0]          game_rdata;
    logic                vid_req;
    logic [7:0]          vid_idx;
    logic                vid_ack;
    logic [1:0]          vid_rdata;
    logic [7:0]          food_left;
    logic                ready;
    logic                level_done;

    int                  tests = 0;
    int                  failures = 0;
    int                  ld_count = 0;
    logic [1:0]          ref_map [NC];
    logic                ack_ld;
    logic                ack_ready;

    always #5 clk = ~clk;

    always @(posedge clk) if (level_done === 1'b1) ld_count++;

    field_arbiter #(
        .MAX_WAIT   (TB_WAIT),
        .GEN_RST_CY (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gen_rst    (gen_rst),
        .gen_busy   (gen_busy),
        .gen_food   (gen_food),
        .new_level  (new_level),
        .game_req   (game_req),
        .game_we    (game_we),
        .game_idx   (game_idx),
        .game_wdata (game_wdata),
        .game_ack   (game_ack),
        .game_rdata (game_rdata),
        .vid_req    (vid_req),
        .vid_idx    (vid_idx),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .food_left  (food_left),
        .ready      (ready),
        .level_done (level_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_food();
        int n = 0;
        for (int i = 0; i < NC; i++) if (ref_map[i] == CELL_FOOD) n++;
        return n;
    endfunction

    function automatic logic [1:0] ref_cell(input logic [7:0] idx);
        return (int'(idx) < NC) ? ref_map[idx] : CELL_WALL;
    endfunction

    function automatic logic [2*NC-1:0] pack_map();
        logic [2*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[2*i +: 2] = ref_map[i];
        return v;
    endfunction

    task automatic make_map(input int pct);
        int r;
        for (int i = 0; i < NC; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < pct)           ref_map[i] = CELL_FOOD;
            else if (r < pct + 8)  ref_map[i] = CELL_WALL;
            else if (r < pct + 12) ref_map[i] = 2'b00;
            else                   ref_map[i] = CELL_EMPTY;
        end
    endtask

    // Generator holds busy with junk on its map output, then presents the real map.
    task automatic run_generator(input int busy_cy, output int lat);
        gen_busy = 1'b1;
        for (int i = 0; i < NC; i++) gen_food[2*i +: 2] = 2'($urandom);
        repeat (busy_cy) begin @(posedge clk); #1; end
        gen_busy = 1'b0;
        gen_food = pack_map();
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ready && lat < 400);
        $display("[TB] generator load busy=%0d ready_after=%0d food_left=%0d", busy_cy, lat, food_left);
    endtask

    task automatic game_access(input logic we, input logic [7:0] idx, input logic [1:0] wd,
                               output logic [1:0] rd, output int lat);
        game_req = 1'b1; game_we = we; game_idx = idx; game_wdata = wd; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!game_ack && lat < 50);
        rd = game_rdata; ack_ld = level_done; ack_ready = ready;
        game_req = 1'b0;
        $display("[TB] game %s idx=%0d wdata=%0d rdata=%0d lat=%0d food_left=%0d",
                 we ? "wr" : "rd", idx, wd, rd, lat, food_left);
        @(posedge clk); #1;
    endtask

    task automatic vid_access(input logic [7:0] idx, output logic [1:0] rd, output int lat);
        vid_req = 1'b1; vid_idx = idx; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!vid_ack && lat < 50);
        rd = vid_rdata;
        vid_req = 1'b0;
        $display("[TB] vid rd idx=%0d rdata=%0d lat=%0d", idx, rd, lat);
        @(posedge clk); #1;
    endtask

    task automatic sweep(input string tag);
        int derr = 0;
        int lat;
        logic [1:0] rd;
        for (int i = 0; i < NC; i++) begin
            vid_access(8'(i), rd, lat);
            if (rd !== ref_map[i] || lat != 1) derr++;
        end
        check(tag, derr, 0);
    endtask

    initial begin
        int lat, hi, ld0, gap, max_gap, gacks, vacks, both, derr, acks;
        logic [1:0] rd, exp, wd;
        logic [7:0] idx, prev;

        rst = 1'b1; gen_busy = 1'b1; gen_food = '0; new_level = 1'b0;
        game_req = 1'b0; game_we = 1'b0; game_idx = '0; game_wdata = '0;
        vid_req = 1'b0; vid_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gen_rst", 32'(gen_rst), 1);
        check("rst_ready", 32'(ready), 0);
        check("rst_food_left", 32'(food_left), 0);
        check("rst_acks", 32'({game_ack, vid_ack, level_done}), 0);

        // gen_rst must stay high for exactly two cycles after reset release
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (gen_rst) hi++;
            @(posedge clk); #1;
        end
        check("gen_rst_len", hi, 2);

        make_map(25);
        ref_map[12] = CELL_FOOD;
        run_generator(14, lat);
        // snapshot edge plus 150 scan cycles
        check("ready_latency", lat, 151);
        check("food_left_init", 32'(food_left), count_food());
        check("gen_rst_low_run", 32'(gen_rst), 0);

        new_level = 1'b1; @(posedge clk); #1; new_level = 1'b0;
        @(posedge clk); #1;
        check("new_level_ignored", 32'({ready, gen_rst}), 32'(2'b10));

        prev = food_left;
        game_access(1'b1, 8'd12, CELL_EMPTY, rd, lat);
        check("wr12_lat", lat, 1);
        check("wr12_rdata", 32'(rd), 32'(CELL_FOOD));
        ref_map[12] = CELL_EMPTY;
        check("wr12_food_dec", 32'(food_left), 32'(prev) - 1);

        for (int t = 0; t < 30; t++) begin
            idx = 8'($urandom_range(0, NC + 20));
            exp = ref_cell(idx);
            if ($urandom_range(0, 1) == 1) begin
                wd = 2'($urandom_range(0, 3));
                game_access(1'b1, idx, wd, rd, lat);
                check("rnd_wr_rdata", 32'(rd), 32'(exp));
                if (int'(idx) < NC) ref_map[idx] = wd;
                check("rnd_wr_food", 32'(food_left), count_food());
            end else begin
                vid_access(idx, rd, lat);
                check("rnd_vid_rdata", 32'(rd), 32'(exp));
            end
            check("rnd_lat", lat, 1);
        end

        prev = food_left;
        game_access(1'b0, 8'd200, 2'b00, rd, lat);
        check("oob_rd", 32'(rd), 32'(CELL_WALL));
        game_access(1'b1, 8'd200, CELL_FOOD, rd, lat);
        check("oob_wr_rdata", 32'(rd), 32'(CELL_WALL));
        check("oob_wr_lat", lat, 1);
        check("oob_food", 32'(food_left), 32'(prev));
        vid_access(8'd200, rd, lat);
        check("oob_vid", 32'(rd), 32'(CELL_WALL));
        sweep("sweep_run");

        // both ports held: one ack per cycle, video never waits long, game keeps flowing
        game_we = 1'b0;
        game_idx = 8'($urandom_range(0, NC - 1));
        vid_idx  = 8'($urandom_range(0, NC - 1));
        game_req = 1'b1; vid_req = 1'b1;
        gap = 0; max_gap = 0; gacks = 0; vacks = 0; both = 0; derr = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (game_ack && vid_ack) both++;
            if (game_ack) begin
                gacks++;
                if (game_rdata !== ref_map[game_idx]) derr++;
            end
            if (vid_ack) begin
                vacks++;
                if (vid_rdata !== ref_map[vid_idx]) derr++;
                gap = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
        end
        game_req = 1'b0; vid_req = 1'b0;
        @(posedge clk); #1;
        $display("[TB] contention game_acks=%0d vid_acks=%0d max_gap=%0d", gacks, vacks, max_gap);
        check("contend_vid_gap", 32'(max_gap <= TB_WAIT + 1), 1);
        check("contend_game_flow", 32'(gacks >= 20), 1);
        check("contend_one_ack", both, 0);
        check("contend_data", derr, 0);

        ld0 = ld_count;
        for (int i = 0; i < NC; i++) begin
            if (ref_map[i] == CELL_FOOD) begin
                game_access(1'b1, 8'(i), CELL_EMPTY, rd, lat);
                ref_map[i] = CELL_EMPTY;
                if (count_food() == 0) begin
                    check("last_eat_level_done", 32'(ack_ld), 1);
                    check("last_eat_ready", 32'(ack_ready), 0);
                end else begin
                    check("eat_food_left", 32'(food_left), count_food());
                end
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        check("level_done_once", ld_count - ld0, 1);
        check("done_ready", 32'(ready), 0);
        check("done_food_left", 32'(food_left), 0);

        exp = ref_map[5];
        game_access(1'b1, 8'd5, CELL_FOOD, rd, lat);
        check("done_wr_ack", lat, 1);
        check("done_wr_rdata", 32'(rd), 32'(exp));
        game_access(1'b0, 8'd5, 2'b00, rd, lat);
        check("done_wr_ignored", 32'(rd), 32'(exp));
        check("done_food_stays", 32'(food_left), 0);

        make_map(15);
        new_level = 1'b1; @(posedge clk); #1; new_level = 1'b0;
        check("regen_gen_rst", 32'(gen_rst), 1);
        run_generator(5, lat);
        check("regen_latency", lat, 151);
        check("regen_food_left", 32'(food_left), count_food());
        check("regen_no_level_done", ld_count - ld0, 1);
        sweep("sweep_regen");

        // reset from S_RUN, then reset again partway through the count
        rst = 1'b1; gen_busy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        make_map(20);
        ref_map[0] = CELL_FOOD;
        repeat (6) begin @(posedge clk); #1; end
        gen_busy = 1'b0;
        gen_food = pack_map();
        game_req = 1'b1; game_we = 1'b0; game_idx = 8'd3;
        acks = 0;
        repeat (40) begin @(posedge clk); #1; if (game_ack) acks++; end
        check("count_no_ack", acks, 0);
        check("count_not_ready", 32'(ready), 0);
        rst = 1'b1; gen_busy = 1'b1;
        @(posedge clk); #1;
        check("midrst_food_left", 32'(food_left), 0);
        check("midrst_gen_rst", 32'(gen_rst), 1);
        check("midrst_outs", 32'({ready, game_ack, level_done}), 0);
        @(posedge clk); #1;
        rst = 1'b0; game_req = 1'b0;
        make_map(20);
        run_generator(20, lat);
        check("restart_latency", lat, 151);
        check("restart_food_left", 32'(food_left), count_food());
        idx = 8'($urandom_range(0, NC - 1));
        game_access(1'b0, idx, 2'b00, rd, lat);
        check("restart_rd", 32'(rd), 32'(ref_map[idx]));
        check("restart_rd_lat", lat, 1);
        sweep("sweep_restart");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
